// File: rtl/dot_product_engine.sv
// Streaming dot-product engine: unsigned multiply-accumulate or binary AND-popcount over
// multi-beat vectors. Define DOTP_SAT_EN for a saturating accumulator (default wraps).
module dot_product_engine #(
  parameter int ELEM_W = 4,
  parameter int LANES  = 4,
  parameter int ACC_W  = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ELEM_W-1:0]   in_a,
  input  logic [LANES*ELEM_W-1:0]   in_b,
  input  logic                      in_last,
  input  logic                      mode,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_W-1:0]          out_result,
  output logic                      out_ovf
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic             sticky_q, sticky_d;
  logic             ovf_q, ovf_d;
  logic             valid_q, valid_d;
  logic             mode_q, mode_d;

  logic             accept;
  logic             eff_mode;
  logic [ACC_W:0]   beat_sum;
  logic [ACC_W:0]   next_sum;
  logic [ACC_W-1:0] next_val;
  logic             ovf_now;

  assign in_ready   = (state_q != DONE);
  assign accept     = in_valid && in_ready;
  assign out_valid  = valid_q;
  assign out_result = result_q;
  assign out_ovf    = ovf_q;

  // Mode comes from the port on the first beat of a vector, from the latch afterwards.
  assign eff_mode = (state_q == IDLE) ? mode : mode_q;

  always_comb begin
    logic [2*ELEM_W-1:0] a_ext;
    logic [2*ELEM_W-1:0] b_ext;
    logic [2*ELEM_W-1:0] prod;
    logic [ELEM_W-1:0]   and_bits;
    // NOTE: every combinational output gets a default before any branch; a path that
    // leaves one unassigned infers a latch.
    beat_sum = '0;
    a_ext    = '0;
    b_ext    = '0;
    prod     = '0;
    and_bits = '0;
    for (int i = 0; i < LANES; i++) begin
      if (eff_mode) begin
        and_bits = in_a[i*ELEM_W +: ELEM_W] & in_b[i*ELEM_W +: ELEM_W];
        for (int j = 0; j < ELEM_W; j++) begin
          beat_sum = beat_sum + (ACC_W+1)'(and_bits[j]);
        end
      end else begin
        a_ext    = {{ELEM_W{1'b0}}, in_a[i*ELEM_W +: ELEM_W]};
        b_ext    = {{ELEM_W{1'b0}}, in_b[i*ELEM_W +: ELEM_W]};
        prod     = a_ext * b_ext;
        beat_sum = beat_sum + (ACC_W+1)'(prod);
      end
    end
  end

  // A new vector starts from zero with a clear sticky bit; the carry out of the
  // ACC_W+1-bit sum is this beat's overflow.
  always_comb begin
    next_sum = ((state_q == IDLE) ? '0 : {1'b0, acc_q}) + beat_sum;
    ovf_now  = next_sum[ACC_W] || ((state_q != IDLE) && sticky_q);
`ifdef DOTP_SAT_EN
    next_val = ovf_now ? '1 : next_sum[ACC_W-1:0];
`else
    next_val = next_sum[ACC_W-1:0];
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      result_q <= '0;
      sticky_q <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      mode_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      sticky_q <= sticky_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      mode_q   <= mode_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACCUM: begin
        if (accept) state_d = in_last ? DONE : ACCUM;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    acc_d    = acc_q;
    result_d = result_q;
    sticky_d = sticky_q;
    ovf_d    = ovf_q;
    valid_d  = valid_q;
    mode_d   = mode_q;
    if (accept) begin
      if (state_q == IDLE) mode_d = mode;
      if (in_last) begin
        result_d = next_val;
        ovf_d    = ovf_now;
        valid_d  = 1'b1;
        acc_d    = '0;
        sticky_d = 1'b0;
      end else begin
        acc_d    = next_val;
        sticky_d = ovf_now;
      end
    end
    if ((state_q == DONE) && out_ready) valid_d = 1'b0;
  end

endmodule

// File: tb/tb_dot_product_engine.sv
// Self-checking bench for dot_product_engine: directed vectors, a vector-level reference
// model compared every cycle, and hand-computed literal expectations.
module tb_dot_product_engine;

  localparam int ELEM_W = 4;
  localparam int LANES  = 4;
  localparam int ACC_W  = 16;
  localparam int DW     = LANES * ELEM_W;
  localparam longint ACC_MAX = (64'd1 << ACC_W) - 1;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic          in_last;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [ACC_W-1:0] out_result;
  logic          out_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  dot_product_engine #(.ELEM_W(ELEM_W), .LANES(LANES), .ACC_W(ACC_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_b       (in_b),
    .in_last    (in_last),
    .mode       (mode),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_ovf    (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: whole-vector arithmetic in unbounded integers.
  function automatic longint beat_value(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                        input logic md);
    longint s;
    s = 0;
    if (md) begin
      s = $countones(a & b);
    end else begin
      for (int i = 0; i < LANES; i++) s += a[i*ELEM_W +: ELEM_W] * b[i*ELEM_W +: ELEM_W];
    end
    return s;
  endfunction

  logic       m_pending, m_in_vec, m_vmode, m_exp_ovf;
  longint     m_total, m_next;
  logic [ACC_W-1:0] m_exp_res;
  logic       m_mode, m_accept;

  always_comb begin
    m_accept = in_valid && !m_pending;
    m_mode   = m_in_vec ? m_vmode : mode;
    m_next   = (m_in_vec ? m_total : 64'd0) + beat_value(in_a, in_b, m_mode);
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pending <= 1'b0;
      m_in_vec  <= 1'b0;
      m_vmode   <= 1'b0;
      m_total   <= 0;
      m_exp_res <= '0;
      m_exp_ovf <= 1'b0;
    end else begin
      if (m_pending && out_ready) m_pending <= 1'b0;
      if (m_accept) begin
        m_vmode <= m_mode;
        if (in_last) begin
          m_pending <= 1'b1;
          m_in_vec  <= 1'b0;
          m_total   <= 0;
          m_exp_ovf <= (m_next > ACC_MAX);
`ifdef DOTP_SAT_EN
          m_exp_res <= (m_next > ACC_MAX) ? ACC_W'(ACC_MAX) : m_next[ACC_W-1:0];
`else
          m_exp_res <= m_next[ACC_W-1:0];
`endif
        end else begin
          m_in_vec <= 1'b1;
          m_total  <= m_next;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("model_in_ready", 32'(in_ready), 32'(!m_pending));
      check("model_out_valid", 32'(out_valid), 32'(m_pending));
      if (m_pending) begin
        check("model_out_result", 32'(out_result), 32'(m_exp_res));
        check("model_out_ovf", 32'(out_ovf), 32'(m_exp_ovf));
      end
    end
  end

  task automatic send_beat(input logic [DW-1:0] a, input logic [DW-1:0] b,
                           input logic last, input logic md);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    mode     = md;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) begin
        @(posedge clk);
        #1;
        done = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    if (!done) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic wait_valid();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    if (!seen) check("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic expect_result(input string name, input logic [ACC_W-1:0] res, input logic ovf);
    check({name, "_result"}, 32'(out_result), 32'(res));
    check({name, "_ovf"}, 32'(out_ovf), 32'(ovf));
  endtask

  // Entered at a falling edge with out_valid high; holds out_ready low, then handshakes.
  task automatic handshake(input string name, input int hold);
    logic [ACC_W-1:0] held;
    held = out_result;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({name, "_hold_valid"}, 32'(out_valid), 32'd1);
      check({name, "_hold_in_ready"}, 32'(in_ready), 32'd0);
      check({name, "_hold_stable"}, 32'(out_result), 32'(held));
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, "_post_in_ready"}, 32'(in_ready), 32'd1);
    check({name, "_post_out_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    mode      = 1'b0;
    out_ready = 1'b0;
    #12;
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_result", 32'(out_result), 32'd0);
    check("reset_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Multiply mode, one beat: 1*5 + 2*6 + 3*7 + 4*8 = 70.
    send_beat(16'h4321, 16'h8765, 1'b1, 1'b0);
    idle_inputs();
    @(negedge clk);
    check("t1_valid_next_cycle", 32'(out_valid), 32'd1);
    expect_result("t1", 16'd70, 1'b0);
    handshake("t1", 0);

    // Popcount mode: 0xFFFF & 0x0F0F has 8 ones.
    send_beat(16'hFFFF, 16'h0F0F, 1'b1, 1'b1);
    idle_inputs();
    wait_valid();
    expect_result("t2", 16'd8, 1'b0);
    handshake("t2", 0);

    // Three beats of 16 with a gap after the first, then 3 cycles of back-pressure.
    send_beat(16'h2222, 16'h2222, 1'b0, 1'b0);
    idle_inputs();
    @(posedge clk);
    #1;
    send_beat(16'h2222, 16'h2222, 1'b0, 1'b1);
    send_beat(16'h2222, 16'h2222, 1'b1, 1'b1);
    idle_inputs();
    wait_valid();
    expect_result("t3", 16'd48, 1'b0);
    handshake("t3", 3);

    // 73 back-to-back beats of 900: total 65700 overflows 16 bits.
    for (int i = 0; i < 73; i++) send_beat(16'hFFFF, 16'hFFFF, (i == 72), 1'b0);
    idle_inputs();
    wait_valid();
`ifdef DOTP_SAT_EN
    expect_result("t4", 16'd65535, 1'b1);
`else
    expect_result("t4", 16'd164, 1'b1);
`endif
    handshake("t4", 0);

    // Asynchronous reset mid-vector discards the partial sum.
    send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    send_beat(16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    idle_inputs();
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #2;
    check("t5_reset_out_valid", 32'(out_valid), 32'd0);
    check("t5_reset_in_ready", 32'(in_ready), 32'd1);
    #2;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    send_beat(16'h0001, 16'h0003, 1'b1, 1'b0);
    idle_inputs();
    wait_valid();
    expect_result("t5", 16'd3, 1'b0);
    handshake("t5", 0);

    // Mode is latched on the first beat: both beats multiply.
    send_beat(16'h1111, 16'h1111, 1'b0, 1'b0);
    send_beat(16'h1111, 16'h1111, 1'b1, 1'b1);
    idle_inputs();
    wait_valid();
    expect_result("t6", 16'd8, 1'b0);
    handshake("t6", 0);

    // Same with lanes of 3, where the modes differ: 36 + 36 = 72 (popcount would give 44).
    send_beat(16'h3333, 16'h3333, 1'b0, 1'b0);
    send_beat(16'h3333, 16'h3333, 1'b1, 1'b1);
    idle_inputs();
    wait_valid();
    expect_result("t7", 16'd72, 1'b0);
    handshake("t7", 0);

    // Popcount latched on the first beat: 8 + 8 = 16 (multiply would give 2*4*9 = 72).
    send_beat(16'h3333, 16'h3333, 1'b0, 1'b1);
    send_beat(16'h3333, 16'h3333, 1'b1, 1'b0);
    idle_inputs();
    wait_valid();
    expect_result("t8", 16'd16, 1'b0);
    handshake("t8", 0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
